dma_io_drain: RTL and testbench

//  DMA-side responder to the buffered IO device. On a device request (GPIO high) it wins the memory
//  bus and asserts Ack with IOWrite=0, streaming device words into memory from cfg_base upward.

---
 rtl/dma_io_drain_pkg.sv | 14 +
 rtl/dma_io_drain_if.sv | 42 ++++
 rtl/dma_io_drain_fifo.sv | 52 +++++
 rtl/dma_io_drain.sv | 143 ++++++++++++++
 tb/tb_dma_io_drain.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dma_io_drain_pkg.sv
// Shared definitions for the IO-drain DMA channel: word width and FSM state encoding.
package dma_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/dma_io_drain_if.sv
// Signal bundle between the DMA channel and its surroundings: buffered IO device,
// memory bus, and CPU-side configuration/status.
// master = DMA channel side, slave = device/memory/CPU side.
interface dma_io_drain_if #(
  parameter int AW = 9,
  parameter int CW = 6
);
  import dma_pkg::*;

  // IO device handshake
  logic              gpio;
  logic              io_ack;
  logic              io_write;
  logic              io_valid;
  logic [DATA_W-1:0] io_data;
  // memory bus
  logic              bus_req;
  logic              bus_grant;
  logic              mem_we;
  logic              mem_ready;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  // configuration and status
  logic              cfg_en;
  logic [AW-1:0]     cfg_base;
  logic [CW-1:0]     cfg_max;
  logic              busy;
  logic              done;
  logic [CW-1:0]     xfer_cnt;
  logic              irq;

  modport master (
    input  gpio, io_valid, io_data, bus_grant, mem_ready, cfg_en, cfg_base, cfg_max,
    output io_ack, io_write, bus_req, mem_we, mem_addr, mem_wdata, busy, done, xfer_cnt, irq
  );

  modport slave (
    output gpio, io_valid, io_data, bus_grant, mem_ready, cfg_en, cfg_base, cfg_max,
    input  io_ack, io_write, bus_req, mem_we, mem_addr, mem_wdata, busy, done, xfer_cnt, irq
  );

endinterface

// File: rtl/dma_io_drain_fifo.sv
// Small synchronous skid FIFO (module dma_sync_fifo). DEPTH must be a power of two
// so the pointers wrap naturally. Storage is not reset; only the pointers and count are.
module dma_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != FULL_LVL);
  assign w_do_pop  = i_pop && (r_count != '0);

  // Data storage: write slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/dma_io_drain.sv
// DMA channel that drains a buffered IO device into memory starting at cfg_base.
// Optional feature macro: DMA_IRQ_EN (sticky completion interrupt); without it irq is tied low.
module dma_io_drain
  import dma_pkg::*;
#(
  parameter int AW         = 9,
  parameter int CW         = 6,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  dma_io_drain_if.master bus
);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] AFULL_LVL = FCW'(FIFO_DEPTH - 2);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  state_t            r_state;
  logic [AW-1:0]     r_addr;
  logic [CW-1:0]     r_max;
  logic [CW-1:0]     r_pushed;
  logic [CW-1:0]     r_xfer_cnt;
  logic              r_ack_p1;

  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_fifo_empty;
  logic [FCW-1:0]    w_fifo_cnt;
  logic              w_active;
  logic              w_afull;
  logic              w_limited;
  logic              w_limit_hit;
  logic              w_limit_near;
  logic [CW:0]       w_issued;
  logic              w_io_ack;
  logic              w_push;
  logic              w_pop;
  logic              w_mem_we;
  logic              w_start;
  logic              w_xfer_end;
  logic              w_drain_end;

  assign w_active  = (r_state == ST_XFER) || (r_state == ST_DRAIN);
  // Two-entry margin covers the word already requested by last cycle's ack.
  assign w_afull   = (w_fifo_cnt >= AFULL_LVL);
  assign w_limited = (r_max != '0);
  assign w_limit_hit = w_limited && (r_pushed == r_max);
  // Words pushed plus the one still in flight from last cycle's ack; stop asking once
  // that reaches the limit so the device never hands over a word we would drop.
  assign w_issued     = {1'b0, r_pushed} + {{CW{1'b0}}, r_ack_p1};
  assign w_limit_near = w_limited && (w_issued >= {1'b0, r_max});

  assign w_io_ack = (r_state == ST_XFER) && !w_afull && !w_limit_near;
  assign w_push   = w_active && bus.io_valid && !w_limit_hit;
  assign w_mem_we = w_active && !w_fifo_empty && bus.bus_grant;
  assign w_pop    = w_mem_we && bus.mem_ready;

  assign w_start     = bus.cfg_en && bus.gpio;
  assign w_xfer_end  = (!bus.gpio && !bus.io_valid) || w_limit_hit;
  assign w_drain_end = w_fifo_empty && !bus.io_valid && !r_ack_p1;

  dma_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (bus.io_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  // Channel FSM with address, limit and word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_max      <= '0;
      r_pushed   <= '0;
      r_xfer_cnt <= '0;
      r_ack_p1   <= 1'b0;
    end else begin
      r_ack_p1 <= w_io_ack;
      if (w_push) r_pushed <= sat_inc(r_pushed);
      if (w_pop) begin
        r_addr     <= r_addr + 1'b1;
        r_xfer_cnt <= sat_inc(r_xfer_cnt);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_ARB;
            r_addr     <= bus.cfg_base;
            r_max      <= bus.cfg_max;
            r_pushed   <= '0;
            r_xfer_cnt <= '0;
          end
        end
        ST_ARB:   if (bus.bus_grant) r_state <= ST_XFER;
        ST_XFER:  if (w_xfer_end)    r_state <= ST_DRAIN;
        ST_DRAIN: if (w_drain_end)   r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DMA_IRQ_EN
  logic r_irq;

  // Sticky interrupt: rises together with done, cleared when the next transfer starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_start) begin
      r_irq <= 1'b0;
    end else if ((r_state == ST_DRAIN) && w_drain_end) begin
      r_irq <= 1'b1;
    end
  end

  assign bus.irq = r_irq;
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.io_ack    = w_io_ack;
  assign bus.io_write  = 1'b0;
  assign bus.bus_req   = (r_state == ST_ARB) || w_active;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = w_fifo_dout;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_dma_io_drain.sv
// Bench for dma_io_drain: a queue-based device model feeds words on ack with one cycle
// latency, and the expected memory image (address/data list, final count) is computed
// from the device contents, base, limit and address wrap.
module tb_dma_io_drain;
  localparam int AW = 9;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_io_drain_if #(.AW(AW), .CW(CW)) bus ();

  dma_io_drain #(.AW(AW), .CW(CW), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]   dev_q [$];
  logic [AW-1:0] exp_addr_q [$];
  logic [31:0]   exp_data_q [$];
  logic          ack_prev = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;
  int delivered = 0, written = 0, limit_n = 0, done_cnt = 0, run_cyc = 0;
  int acc = 0, occ = 0;
  int ready_mode = 0, stall_start = 0, grant_mode = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Device and memory environment for one cycle.
  task automatic drive();
    if (bus.io_valid === 1'b1) delivered++;
    if (ack_prev && dev_q.size() > 0) begin
      bus.io_valid = 1'b1;
      bus.io_data  = dev_q.pop_front();
    end else begin
      bus.io_valid = 1'b0;
      bus.io_data  = $urandom;
    end
    bus.gpio = (dev_q.size() > 0);
    case (ready_mode)
      0:       bus.mem_ready = 1'b1;
      1:       bus.mem_ready = ($urandom_range(0, 3) != 0);
      2:       bus.mem_ready = !(run_cyc >= stall_start && run_cyc < stall_start + 10);
      default: bus.mem_ready = 1'b0;
    endcase
    bus.bus_grant = (grant_mode == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
  endtask

  task automatic step();
    @(posedge clk); #1;
    drive(); #1;
    acc = (limit_n != 0 && delivered > limit_n) ? limit_n : delivered;
    occ = acc - written;
    chk("fifo_bound", (occ <= 4), 1);
    if (occ >= 2) chk("ack_afull", bus.io_ack, 0);
    if (limit_n != 0 && delivered >= limit_n) chk("ack_limit", bus.io_ack, 0);
    if (!bus.bus_grant) chk("we_nogrant", bus.mem_we, 0);
    if (prev_stall && bus.mem_we) begin
      chk("stall_addr", bus.mem_addr, prev_addr);
      chk("stall_data", bus.mem_wdata, prev_data);
    end
    if (bus.mem_we && bus.mem_ready) begin
      if (exp_addr_q.size() == 0) begin
        chk("write_overrun", bus.mem_we, 0);
      end else begin
        chk("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
        chk("wr_data", bus.mem_wdata, exp_data_q.pop_front());
      end
      written++;
    end
    prev_stall = bus.mem_we && !bus.mem_ready;
    prev_addr  = bus.mem_addr;
    prev_data  = bus.mem_wdata;
    if (bus.done) done_cnt++;
    ack_prev = bus.io_ack;
    run_cyc++;
  endtask

  task automatic run(input logic [AW-1:0] base, input logic [CW-1:0] maxv,
                     input int rm, input int gm, input string name);
    int n;
    int nexp;
    int bound;
    n    = dev_q.size();
    nexp = (maxv != 0 && n > int'(maxv)) ? int'(maxv) : n;
    for (int i = 0; i < nexp; i++) begin
      exp_addr_q.push_back(base + AW'(i));
      exp_data_q.push_back(dev_q[i]);
    end
    limit_n = int'(maxv); delivered = 0; written = 0; done_cnt = 0; run_cyc = 0;
    ready_mode = rm; grant_mode = gm;
    bus.cfg_base = base; bus.cfg_max = maxv; bus.cfg_en = 1'b1;
    step();
    chk({name, "_idle_busy"}, bus.busy, 0);
    step();
    chk({name, "_bus_req"}, bus.bus_req, 1);
    chk({name, "_irq_clr"}, bus.irq, 0);
    if (gm == 0) begin
      step();
      chk({name, "_grant_to_ack"}, bus.io_ack, 1);
    end
    bound = 0;
    while (done_cnt == 0 && bound < 3000) begin
      step();
      bound++;
    end
    chk({name, "_done_seen"}, done_cnt, 1);
    chk({name, "_xfer_cnt"}, bus.xfer_cnt, (nexp > 63) ? 63 : nexp);
    chk({name, "_writes"}, written, nexp);
    chk({name, "_io_write"}, bus.io_write, 0);
    bus.cfg_en = 1'b0;
    dev_q.delete();
    step();
    chk({name, "_done_pulse"}, bus.done, 0);
    chk({name, "_busy_end"}, bus.busy, 0);
    chk({name, "_req_end"}, bus.bus_req, 0);
`ifdef DMA_IRQ_EN
    chk({name, "_irq_set"}, bus.irq, 1);
`else
    chk({name, "_irq_zero"}, bus.irq, 0);
`endif
    step();
    chk({name, "_done_once"}, done_cnt, 1);
    chk({name, "_exp_left"}, exp_addr_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  initial begin
    int n;
    int bound;
    logic [CW-1:0] mx;
    bus.gpio = 1'b0; bus.io_valid = 1'b0; bus.io_data = '0;
    bus.bus_grant = 1'b0; bus.mem_ready = 1'b0;
    bus.cfg_en = 1'b0; bus.cfg_base = '0; bus.cfg_max = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_io_ack", bus.io_ack, 0);
    chk("rst_bus_req", bus.bus_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_xfer_cnt", bus.xfer_cnt, 0);
    chk("rst_addr", bus.mem_addr, 0);
    rst = 1'b0;
    step();

    // 1: five fixed words, unlimited
    dev_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    run(9'h040, 6'd0, 0, 0, "t1");

    // 2: limit of 3 with 8 words waiting
    for (int i = 0; i < 8; i++) dev_q.push_back($urandom);
    run(9'h080, 6'd3, 0, 0, "t2");

    // 3: memory stalls for 10 cycles mid-stream
    for (int i = 0; i < 12; i++) dev_q.push_back($urandom);
    stall_start = 6;
    run(9'h100, 6'd0, 2, 0, "t3");

    // 4: address wrap
    for (int i = 0; i < 4; i++) dev_q.push_back($urandom);
    run(9'h1FE, 6'd0, 0, 0, "t4");

    // 5: reset in the middle of a transfer with words buffered
    for (int i = 0; i < 8; i++) dev_q.push_back($urandom);
    limit_n = 0; delivered = 0; written = 0; done_cnt = 0; run_cyc = 0;
    ready_mode = 3; grant_mode = 0;
    bus.cfg_base = 9'h010; bus.cfg_max = '0; bus.cfg_en = 1'b1;
    bound = 0;
    while (delivered < 2 && bound < 50) begin
      step();
      bound++;
    end
    chk("t5_buffered", delivered, 2);
    rst = 1'b1;
    step();
    chk("t5_io_ack", bus.io_ack, 0);
    chk("t5_bus_req", bus.bus_req, 0);
    chk("t5_mem_we", bus.mem_we, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_xfer_cnt", bus.xfer_cnt, 0);
    chk("t5_irq", bus.irq, 0);
    chk("t5_addr", bus.mem_addr, 0);
    rst = 1'b0;
    bus.cfg_en = 1'b0;
    dev_q.delete();
    ready_mode = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_we", bus.mem_we, 0);
    end

    // xfer_cnt saturation on a long unlimited transfer
    for (int i = 0; i < 70; i++) dev_q.push_back($urandom);
    run(9'h020, 6'd0, 0, 0, "sat");

    // randomized transfers with random back-pressure and grant
    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 20);
      mx = ($urandom_range(0, 1) == 0) ? 6'd0 : CW'($urandom_range(1, 10));
      for (int i = 0; i < n; i++) dev_q.push_back($urandom);
      run(AW'($urandom), mx, 1, 1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
